// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO plus word packer feeding a multi-byte UART transmitter.
//   Bytes are queued, then DATA_WIDTH/8 of them are packed into one word
//   (first byte in the MSBs). A one-cycle send_en accompanies each word, and
//   no further word is started until the transmitter answers with Tx_Done.
//
// Ports
//   Clk, Rst        clock (rising edge), asynchronous active-high reset
//   wr_data, wr_en  byte enqueue, one byte per cycle
//   flush           pulse: send the pending partial word, zero padded
//   full, empty     FIFO status (registered)
//   count           FIFO occupancy (registered)
//   wr_drop         one-cycle pulse: a write arrived while full and was lost
//   data, send_en   packed word and its start strobe to the transmitter
//   Tx_Done         one-cycle pulse from the transmitter: word sent
//   busy            packer is not idle
//
// Optional build macro: UART_FEED_TIMEOUT_EN
//   When defined, a partial word left idle for TIMEOUT_CYCLES cycles is
//   flushed automatically. When undefined, a partial word leaves only on flush.

module uart_tx_feeder #(
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_drop,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  send_en,
  input  logic                  Tx_Done,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH:0]   C_ZERO  = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0]   C_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   C_BYTES = (ADDR_WIDTH+1)'(BYTES);
  localparam logic [ADDR_WIDTH:0]   C_LAST  = (ADDR_WIDTH+1)'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   C_DEPTH = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] P_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t                r_state;
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_ld_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_flush_pend;

  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic [7:0]            w_byte;
  logic [DATA_WIDTH-1:0] w_word_next;
  logic                  w_ld_last;
  logic                  w_start;
  logic                  w_timeout;

  // A write is refused whenever the FIFO is full, even if a pop happens in the same cycle.
  assign w_push      = wr_en & ~full;
  assign w_pop       = (r_state == S_LOAD) & ~empty;
  // An empty FIFO during LOAD supplies a zero pad byte instead of popping.
  assign w_byte      = empty ? 8'h00 : r_mem[r_rptr];
  assign w_word_next = (r_word << 8) | DATA_WIDTH'(w_byte);
  assign w_ld_last   = (r_state == S_LOAD) && (r_ld_cnt == C_LAST);
  assign w_start     = (count >= C_BYTES) || (r_flush_pend && (count != C_ZERO));

  // Next occupancy from this cycle's push/pop pair.
  always_comb begin
    w_count_next = count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = count + C_ONE;
      2'b01:   w_count_next = count - C_ONE;
      default: w_count_next = count;
    endcase
  end

  // Byte storage; contents need no reset because the pointers define validity.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // FIFO pointers, registered status flags and the drop pulse.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      wr_drop <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + P_ONE;
      if (w_pop)  r_rptr <= r_rptr + P_ONE;
      count   <= w_count_next;
      full    <= (w_count_next == C_DEPTH);
      empty   <= (w_count_next == C_ZERO);
      wr_drop <= wr_en & full;
    end
  end

`ifdef UART_FEED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] C_TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] C_TO_FULL = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_run;

  assign w_to_run  = (r_state == S_IDLE) && (count != C_ZERO) && (count < C_BYTES);
  // Fires on the edge where the idle count reaches TIMEOUT_CYCLES.
  assign w_timeout = w_to_run && (r_to_cnt == C_TO_LAST);

  // Idle counter for a stranded partial word; saturates at the timeout value.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_to_cnt <= '0;
    end else if (w_push || ((r_state == S_IDLE) && w_start)) begin
      r_to_cnt <= '0;
    end else if (w_to_run && (r_to_cnt != C_TO_FULL)) begin
      r_to_cnt <= r_to_cnt + C_TO_ONE;
    end
  end
`else
  // No auto-flush in this build; the expression is constant false.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Packer FSM with registered data/send_en/busy and the pending-flush flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state      <= S_IDLE;
      r_ld_cnt     <= '0;
      r_word       <= '0;
      r_flush_pend <= 1'b0;
      data         <= '0;
      send_en      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      send_en <= 1'b0;

      // A flush request on an empty FIFO has nothing to send and is ignored.
      if ((flush || w_timeout) && (count != C_ZERO)) begin
        r_flush_pend <= 1'b1;
      end else if (((r_state == S_IDLE) && (count == C_ZERO)) ||
                   (w_ld_last && (w_count_next == C_ZERO))) begin
        r_flush_pend <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_LOAD;
            r_ld_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          r_word <= w_word_next;
          if (w_ld_last) begin
            // Word and strobe leave together so the transmitter sees both at once.
            r_state <= S_SEND;
            data    <= w_word_next;
            send_en <= 1'b1;
          end else begin
            r_ld_cnt <= r_ld_cnt + C_ONE;
          end
        end
        S_SEND: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (Tx_Done) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
